// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM states, opcode constants and reset defaults.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SQUASH = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Sequential instruction address; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush wins over load; with neither, contents are held.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;

    // A flush only clears valid; the stale word is harmless once marked invalid.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc4_d   = pc4_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc4   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, fetch FSM, one-entry hold buffer and the IF/ID register.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic         if_valid,
    output logic [31:0]  if_instr,
    output logic [31:0]  if_pc4,
    output logic [5:0]   instr_op,
    output fetch_state_e dbg_state
);

    // Handshake: a fetch completes in a cycle where imem_req=1 and imem_ready=1; while
    // imem_req=1 and imem_ready=0, imem_addr holds steady. imem_ready is ignored when imem_req=0.

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  squash_addr_q, squash_addr_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;

    logic         id_load;
    logic         id_flush;
    logic [31:0]  id_instr;
    logic [31:0]  id_pc4;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        squash_addr_d = squash_addr_q;
        hold_instr_d  = hold_instr_q;
        hold_pc4_d    = hold_pc4_q;
        id_load       = 1'b0;
        id_flush      = 1'b0;
        id_instr      = imem_rdata;
        id_pc4        = pc_plus4(fetch_pc_q);
        imem_req      = 1'b0;
        imem_addr     = fetch_pc_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    id_flush   = 1'b1;
                    fetch_pc_d = branch_target;
                    if (!imem_ready) begin
                        // The in-flight request must finish at its original address.
                        squash_addr_d = fetch_pc_q;
                        state_d       = ST_SQUASH;
                    end
                end else if (imem_ready) begin
                    fetch_pc_d = pc_plus4(fetch_pc_q);
                    if (stall && if_valid) begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4(fetch_pc_q);
                        state_d      = ST_HOLD;
                    end else begin
                        id_load = 1'b1;
                    end
                end else if (!stall) begin
                    id_flush = 1'b1;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    id_flush   = 1'b1;
                    fetch_pc_d = branch_target;
                    state_d    = ST_REQ;
                end else if (!stall) begin
                    id_load  = 1'b1;
                    id_instr = hold_instr_q;
                    id_pc4   = hold_pc4_q;
                    state_d  = ST_REQ;
                end
            end

            ST_SQUASH: begin
                imem_req  = 1'b1;
                imem_addr = squash_addr_q;
                id_flush  = 1'b1;
                if (branch_taken) begin
                    fetch_pc_d = branch_target;
                end
                if (imem_ready) begin
                    state_d = ST_REQ;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            squash_addr_q <= RESET_PC;
            hold_instr_q  <= NOP_WORD;
            hold_pc4_q    <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            squash_addr_q <= squash_addr_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc4_q    <= hold_pc4_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (id_load),
        .flush    (id_flush),
        .instr_in (id_instr),
        .pc4_in   (id_pc4),
        .valid    (if_valid),
        .instr    (if_instr),
        .pc4      (if_pc4)
    );

    assign instr_op  = if_instr[31:26];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/branch/wait-state traffic against a queue-based fetch model.
module tb_if_stage;
    import mips_pkg::*;

    localparam logic [31:0] RP_ALT = 32'h0000_0100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, stall, branch_taken, imem_ready;
    logic [31:0]  branch_target, imem_rdata;
    logic         imem_req, if_valid;
    logic [31:0]  imem_addr, if_instr, if_pc4;
    logic [5:0]   instr_op;
    fetch_state_e dbg_state;

    logic         rp_imem_req, rp_if_valid;
    logic [31:0]  rp_imem_addr, rp_if_instr, rp_if_pc4;
    logic [5:0]   rp_instr_op;
    fetch_state_e rp_dbg_state;

    if_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
        .instr_op(instr_op), .dbg_state(dbg_state)
    );

    // Second instance with a non-zero reset PC and a memory that never answers.
    if_stage #(.RESET_PC(RP_ALT)) dut_rp (
        .clk(clk), .rst(rst), .imem_req(rp_imem_req), .imem_addr(rp_imem_addr),
        .imem_ready(1'b0), .imem_rdata(32'h0), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .if_valid(rp_if_valid), .if_instr(rp_if_instr), .if_pc4(rp_if_pc4),
        .instr_op(rp_instr_op), .dbg_state(rp_dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%08h exp=%08h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0000;
            32'h0000_0004: return 32'h8C01_0004;
            32'h0000_0008: return 32'hAC01_0008;
            32'h0000_000C: return 32'h1022_0003;
            default:       return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // exp_q holds {instr, pc4} of words fetched but not yet presented on IF/ID.
    logic [63:0] exp_q[$];
    bit          m_started, m_discard, m_id_valid, rp_started;
    logic [31:0] m_pc, m_squash_addr, m_id_instr, m_id_pc4;

    task automatic model_reset();
        m_started     = 1'b0;
        m_discard     = 1'b0;
        m_pc          = 32'h0;
        m_squash_addr = 32'h0;
        exp_q.delete();
        m_id_valid    = 1'b0;
        m_id_instr    = 32'h0;
        m_id_pc4      = 32'h0;
        rp_started    = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit rdy);
        logic [31:0] w;
        if (r) begin
            model_reset();
            return;
        end
        rp_started = 1'b1;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (exp_q.size() != 0) begin
            if (b) begin
                exp_q.delete();
                m_id_valid = 1'b0;
                m_pc       = t;
            end else if (!s) begin
                {m_id_instr, m_id_pc4} = exp_q.pop_front();
                m_id_valid = 1'b1;
            end
        end else if (m_discard) begin
            m_id_valid = 1'b0;
            if (b) m_pc = t;
            if (rdy) m_discard = 1'b0;
        end else if (b) begin
            m_id_valid = 1'b0;
            if (!rdy) begin
                m_discard     = 1'b1;
                m_squash_addr = m_pc;
            end
            m_pc = t;
        end else if (rdy) begin
            w = word_at(m_pc);
            if (s && m_id_valid) begin
                exp_q.push_back({w, m_pc + 32'd4});
            end else begin
                m_id_instr = w;
                m_id_pc4   = m_pc + 32'd4;
                m_id_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_id_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = m_started && (exp_q.size() == 0);
        check("imem_req", imem_req, exp_req);
        if (exp_req) check("imem_addr", imem_addr, m_discard ? m_squash_addr : m_pc);
        check("if_valid", if_valid, m_id_valid);
        if (m_id_valid) begin
            check("if_instr", if_instr, m_id_instr);
            check("if_pc4", if_pc4, m_id_pc4);
            check("instr_op", instr_op, m_id_instr[31:26]);
        end
        check("rp_imem_req", rp_imem_req, rp_started);
        check("rp_imem_addr", rp_imem_addr, RP_ALT);
        check("rp_if_valid", rp_if_valid, 1'b0);
    endtask

    // ---------------- memory driver ----------------
    int mem_cnt  = 0;
    int mem_ws   = 0;
    int ws_fixed = 0;
    int ws_max   = 3;

    task automatic new_ws();
        mem_ws = (ws_fixed >= 0) ? ws_fixed : int'($urandom_range(0, ws_max));
    endtask

    // One clock cycle: drive inputs, check the DUT against the model, advance the model.
    task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] t);
        bit req_now;
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        req_now       = imem_req;
        if (r)            imem_ready = 1'b0;
        else if (req_now) imem_ready = (mem_cnt >= mem_ws);
        else              imem_ready = 1'($urandom_range(0, 1));
        imem_rdata = req_now ? word_at(imem_addr) : $urandom;
        #2;
        check_outputs();
        model_step(r, s, b, t, imem_ready);
        if (r) begin
            mem_cnt = 0;
            new_ws();
        end else if (req_now) begin
            if (imem_ready) begin
                mem_cnt = 0;
                new_ws();
            end else begin
                mem_cnt++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_instr", if_instr, NOP_WORD);
        check("rst_if_pc4", if_pc4, 32'h0);
        check("rst_instr_op", instr_op, 6'h0);
        check("rst_rp_addr", rp_imem_addr, RP_ALT);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          found;
        bit          r, s, b;
        logic [31:0] t;

        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        imem_ready = 1'b0; imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait program at 0/4/8/C.
        ws_fixed = 0; new_ws();
        do_reset();
        repeat (6) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Two wait states per fetch.
        ws_fixed = 2; new_ws();
        do_reset();
        repeat (14) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Stall for three cycles while the fetch at 8 returns, then reset while in HOLD.
        ws_fixed = 0; new_ws();
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("hold_rst_req", imem_req, 1'b0);
        check("hold_rst_valid", if_valid, 1'b0);
        check("hold_rst_instr", if_instr, NOP_WORD);
        check("hold_rst_addr", imem_addr, 32'h0);

        // Branch to 0x40 while the fetch at C sits in wait states.
        ws_fixed = 2; new_ws();
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_started && exp_q.size() == 0 && !m_discard && m_pc == 32'hC && mem_cnt == 0)
                found = 1'b1;
            else
                cycle(1'b0, 1'b0, 1'b0, 32'h0);
        end
        check("reach_fetch_c", found, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 32'h40);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Branch, stall and ready all in the same cycle; then a wrap past 0xFFFFFFFC.
        ws_fixed = 0; new_ws();
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h80);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        ws_fixed = -1; ws_max = 3; new_ws();
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else                           t = {$urandom, 2'b00} >> 2 << 2;
            cycle(r, s, b, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
